seg7_rx_acc: RTL and testbench

- Receiving end of the 7-segment display bus: watches a raw SEG[7:0] bus (bits 0..6 = segments a..g, active-high; bit 7 = minus sign) and recovers the signed digit shown on it.
- A new code is accepted only after it holds stable for a set number of cycles. Valid codes feed a saturating signed accumulator that either adds or multiplies by the digit.
- Results go to LED/LCD debug outputs at the top level. It is the counterpart of the sign-magnitude digit encoder used on the display side.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_rx_acc_filter.sv | 31 +++
 rtl/seg7_rx_acc.sv | 124 ++++++++++++
 tb/tb_seg7_rx_acc.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, FSM states and the code decoder shared by the seg7 receiver
package seg7_pkg;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int SIGN_BIT = 7;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_e;
  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] value;
  } dec_t;
  function automatic dec_t seg7_decode(input logic [7:0] code);
    dec_t r;
    logic [2:0] mag;
    r.legal = 1'b1;
    r.blank = code[6:0] == SEG_BLANK[6:0];
    mag = 3'd0;
    case (code[6:0])
      SEG_0: mag = 3'd0;
      SEG_1: mag = 3'd1;
      SEG_2: mag = 3'd2;
      SEG_3: mag = 3'd3;
      SEG_4: mag = 3'd4;
      SEG_5: mag = 3'd5;
      SEG_6: mag = 3'd6;
      SEG_7: mag = 3'd7;
      default: r.legal = 1'b0;
    endcase
    // a set sign bit on the zero pattern still yields 0
    r.value = code[SIGN_BIT] ? 4'(-{1'b0, mag}) : {1'b0, mag};
    return r;
  endfunction
endpackage

// File: rtl/seg7_rx_acc_filter.sv
// seg7_stable_filter: tracks how long the raw segment bus has held its current code
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_2,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic [7:0] stable_code,
  output logic       stable
);
  localparam logic [3:0] LIMIT = 4'(STABLE_CYCLES);
  logic [7:0] held_q, held_d;
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    held_d = seg_in;
    cnt_d = seg_in != held_q ? 4'd0 : cnt_q == LIMIT ? cnt_q : cnt_q + 4'd1;
  end
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= SEG_BLANK;
      cnt_q <= 4'd0;
    end else begin
      held_q <= held_d;
      cnt_q <= cnt_d;
    end
  end
  assign stable_code = held_q;
  assign stable = cnt_q == LIMIT;
endmodule

// File: rtl/seg7_rx_acc.sv
// seg7_rx_acc: recovers signed digits from a debounced 7-segment bus and folds them
// into a saturating accumulator by addition or a 3-cycle shift-add multiply
module seg7_rx_acc
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ACC_BITS = 8
) (
  input  logic                clk_2,
  input  logic                rst_n,
  input  logic [7:0]          seg_in,
  input  logic                op,
  input  logic                clear,
  output logic [3:0]          digit_out,
  output logic                digit_valid,
  output logic                err,
  output logic [7:0]          err_cnt,
  output logic [ACC_BITS-1:0] acc_out,
  output logic                result_valid,
  output logic                busy,
  output logic [1:0]          state_out
);
  localparam int W = ACC_BITS + 4;
  localparam int PW = ACC_BITS + 3;
  localparam logic signed [W-1:0] ACC_MAX = W'((1 << (ACC_BITS - 1)) - 1);
  localparam logic signed [W-1:0] ACC_MIN = ~ACC_MAX;
  function automatic logic [ACC_BITS-1:0] sat(input logic signed [W-1:0] v);
    return v > ACC_MAX ? ACC_MAX[ACC_BITS-1:0] : v < ACC_MIN ? ACC_MIN[ACC_BITS-1:0] : v[ACC_BITS-1:0];
  endfunction
  state_e state_q, state_d;
  logic [7:0] last_acc_q, last_acc_d, err_cnt_q, err_cnt_d, stable_code;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic [3:0] digit_q, digit_d;
  logic digit_valid_q, digit_valid_d, err_q, err_d, result_valid_q, result_valid_d;
  logic add_done_q, add_done_d, neg_q, neg_d;
  logic [PW-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [2:0] mplier_q, mplier_d, d_mag;
  logic [1:0] step_q, step_d;
  logic stable, accept, take;
  dec_t dec;
  logic signed [3:0] d_val;
  logic signed [W-1:0] sum_w, prod_w;
  logic [ACC_BITS-1:0] acc_mag;
  seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk_2(clk_2),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .stable_code(stable_code),
    .stable(stable)
  );
  assign dec = seg7_decode(stable_code);
  assign d_val = dec.value;
  assign accept = stable && stable_code != last_acc_q && state_q == IDLE && !clear;
  assign take = accept && dec.legal;
  assign sum_w = W'(acc_q) + W'(d_val);
  assign acc_mag = acc_q[ACC_BITS-1] ? -acc_q : acc_q;
  assign d_mag = d_val[3] ? 3'(-d_val) : d_val[2:0];
  assign prod_w = neg_q ? -$signed({1'b0, prod_q}) : $signed({1'b0, prod_q});
  always_comb begin
    state_d = state_q;
    if (clear) state_d = IDLE;
    else if (take && op) state_d = MUL;
    else if (state_q == MUL && step_q == 2'd2) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  always_comb begin
    last_acc_d = clear ? 8'h00 : accept ? stable_code : last_acc_q;
    digit_d = take ? d_val : digit_q;
    digit_valid_d = take;
    err_d = accept && !dec.legal && !dec.blank;
    err_cnt_d = clear ? 8'd0 : err_d && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
    add_done_d = take && !op;
    result_valid_d = add_done_q || (state_q == DONE && !clear);
    acc_d = clear ? '0 : add_done_d ? sat(sum_w) : state_q == DONE ? sat(prod_w) : acc_q;
    neg_d = take ? acc_q[ACC_BITS-1] ^ d_val[3] : neg_q;
    mcand_d = take ? PW'(acc_mag) : state_q == MUL ? mcand_q << 1 : mcand_q;
    mplier_d = take ? d_mag : state_q == MUL ? mplier_q >> 1 : mplier_q;
    prod_d = take ? '0 : state_q == MUL && mplier_q[0] ? prod_q + mcand_q : prod_q;
    step_d = take ? 2'd0 : state_q == MUL ? step_q + 2'd1 : step_q;
  end
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_acc_q <= SEG_BLANK;
      acc_q <= '0;
      digit_q <= 4'd0;
      digit_valid_q <= 1'b0;
      err_q <= 1'b0;
      err_cnt_q <= 8'd0;
      add_done_q <= 1'b0;
      result_valid_q <= 1'b0;
      neg_q <= 1'b0;
      mcand_q <= '0;
      mplier_q <= 3'd0;
      prod_q <= '0;
      step_q <= 2'd0;
    end else begin
      state_q <= state_d;
      last_acc_q <= last_acc_d;
      acc_q <= acc_d;
      digit_q <= digit_d;
      digit_valid_q <= digit_valid_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
      add_done_q <= add_done_d;
      result_valid_q <= result_valid_d;
      neg_q <= neg_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      prod_q <= prod_d;
      step_q <= step_d;
    end
  end
  always_comb begin
    busy = state_q == MUL;
    state_out = state_q;
  end
  assign digit_out = digit_q;
  assign digit_valid = digit_valid_q;
  assign err = err_q;
  assign err_cnt = err_cnt_q;
  assign acc_out = acc_q;
  assign result_valid = result_valid_q;
endmodule

// File: tb/tb_seg7_rx_acc.sv
// tb_seg7_rx_acc: random and directed segment traffic checked against a sample-history model
module tb_seg7_rx_acc;
  localparam int S = 4;
  localparam int AB = 8;
  logic clk_2 = 0, rst_n = 0, op = 0, clear = 0;
  logic [7:0] seg_in = 0;
  logic [3:0] digit_out;
  logic digit_valid, err, result_valid, busy;
  logic [7:0] err_cnt;
  logic [AB-1:0] acc_out;
  logic [1:0] state_out;
  seg7_rx_acc #(.STABLE_CYCLES(S), .ACC_BITS(AB)) dut (
    .clk_2(clk_2), .rst_n(rst_n), .seg_in(seg_in), .op(op), .clear(clear),
    .digit_out(digit_out), .digit_valid(digit_valid), .err(err), .err_cnt(err_cnt),
    .acc_out(acc_out), .result_valid(result_valid), .busy(busy), .state_out(state_out)
  );
  always #5 clk_2 = ~clk_2;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  int pat [8] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07};
  int hist[$] = '{0};
  int m_last = 0, m_acc = 0, m_digit = 0, m_errc = 0, m_t = 0, m_mul = 0;
  bit m_dv = 0, m_er = 0, m_rv = 0, m_addp = 0;
  function automatic int clamp(int v);
    return v > 127 ? 127 : v < -128 ? -128 : v;
  endfunction
  // 100 = blank, 99 = illegal, otherwise the signed digit
  function automatic int dec_val(int code);
    int m = code & 127;
    if (m == 0) return 100;
    for (int i = 0; i < 8; i++) if (pat[i] == m) return (code & 128) != 0 ? -i : i;
    return 99;
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk_2 or negedge rst_n) begin : model
    int v, held;
    bit st, acpt;
    if (!rst_n) begin
      hist = '{0};
      m_last = 0; m_acc = 0; m_digit = 0; m_errc = 0; m_t = 0; m_mul = 0;
      m_dv = 0; m_er = 0; m_rv = 0; m_addp = 0;
    end else begin
      held = hist[hist.size()-1];
      st = hist.size() == S + 1;
      foreach (hist[i]) if (hist[i] != held) st = 0;
      acpt = st && held != m_last && m_t == 0 && !clear;
      m_dv = 0; m_er = 0; m_rv = m_addp; m_addp = 0;
      if (clear) begin
        m_acc = 0; m_errc = 0; m_last = 0; m_t = 0;
      end else if (m_t == 1) begin
        m_acc = m_mul; m_rv = 1; m_t = 0;
      end else if (m_t > 1) m_t--;
      else if (acpt) begin
        m_last = held;
        v = dec_val(held);
        if (v == 99) begin
          m_er = 1;
          if (m_errc < 255) m_errc++;
        end else if (v != 100) begin
          m_digit = v; m_dv = 1;
          if (!op) begin m_acc = clamp(m_acc + v); m_addp = 1; end
          else begin m_t = 4; m_mul = clamp(m_acc * v); end
        end
      end
      hist.push_back(int'(seg_in));
      if (hist.size() > S + 1) void'(hist.pop_front());
    end
  end
  always @(negedge clk_2) if (chk_en) begin
    chk("digit_out", int'($signed(digit_out)), m_digit);
    chk("digit_valid", int'(digit_valid), int'(m_dv));
    chk("err", int'(err), int'(m_er));
    chk("err_cnt", int'(err_cnt), m_errc);
    chk("acc_out", int'($signed(acc_out)), m_acc);
    chk("result_valid", int'(result_valid), int'(m_rv));
    chk("busy", int'(busy), int'(m_t >= 2));
    chk("state_out", int'(state_out), m_t >= 2 ? 1 : m_t == 1 ? 2 : 0);
  end
  task automatic step(int n);
    repeat (n) begin @(posedge clk_2); #2; end
  endtask
  task automatic show(logic [7:0] c, bit o, int n);
    seg_in = c; op = o; step(n);
  endtask
  initial begin
    step(2);
    rst_n = 1; chk_en = 1;
    chk("lit_reset_acc", int'($signed(acc_out)), 0);
    chk("lit_reset_state", int'(state_out), 0);
    show(8'h06, 0, 6);
    chk("lit_first_valid", int'(digit_valid), 1);
    chk("lit_first_digit", int'($signed(digit_out)), 1);
    show(8'h06, 0, 8);
    chk("lit_hold_acc", int'($signed(acc_out)), 1);
    chk("lit_hold_no_valid", int'(digit_valid), 0);
    show(8'h4F, 0, 2); show(8'h00, 0, 8);
    chk("lit_glitch_acc", int'($signed(acc_out)), 1);
    show(8'hBF, 0, 8);
    chk("lit_neg_zero_digit", int'($signed(digit_out)), 0);
    chk("lit_neg_zero_acc", int'($signed(acc_out)), 1);
    for (int i = 0; i < 19; i++) begin show(8'h07, 0, 7); show(8'h00, 0, 7); end
    chk("lit_sat_hi", int'($signed(acc_out)), 127);
    show(8'h87, 0, 7);
    chk("lit_minus7", int'($signed(acc_out)), 120);
    show(8'h00, 0, 7);
    clear = 1; step(1); clear = 0;
    chk("lit_clear_acc", int'($signed(acc_out)), 0);
    show(8'h6D, 0, 7);
    chk("lit_acc5", int'($signed(acc_out)), 5);
    show(8'hDB, 1, 6);
    chk("lit_mul_busy", int'(busy), 1);
    show(8'h06, 0, 4);
    chk("lit_mul_result", int'(acc_out), 'hF6);
    chk("lit_mul_rv", int'(result_valid), 1);
    step(4);
    chk("lit_after_busy", int'($signed(acc_out)), -9);
    show(8'h07, 1, 10); show(8'h00, 1, 7);
    show(8'h07, 1, 10); show(8'h00, 1, 7);
    show(8'h07, 1, 10);
    chk("lit_sat_lo", int'($signed(acc_out)), -128);
    show(8'h7F, 0, 6);
    chk("lit_err_pulse", int'(err), 1);
    step(1);
    chk("lit_err_cnt", int'(err_cnt), 1);
    chk("lit_err_acc", int'($signed(acc_out)), -128);
    show(8'h00, 0, 7);
    show(8'h5B, 1, 6);
    chk("lit_abort_busy", int'(busy), 1);
    clear = 1; seg_in = 8'h00; step(1); clear = 0;
    chk("lit_abort_acc", int'($signed(acc_out)), 0);
    chk("lit_abort_errcnt", int'(err_cnt), 0);
    chk("lit_abort_state", int'(state_out), 0);
    step(6);
    show(8'h66, 0, 7); show(8'h00, 0, 7);
    show(8'h5B, 1, 6);
    #1 rst_n = 0;
    #1;
    chk("lit_rst_acc", int'(acc_out), 0);
    chk("lit_rst_state", int'(state_out), 0);
    chk("lit_rst_busy", int'(busy), 0);
    chk("lit_rst_digit", int'(digit_out), 0);
    step(2);
    rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      logic [7:0] c;
      c = r < 8 ? 8'(pat[r] | ($urandom_range(0, 1) << 7)) : r == 8 ? 8'($urandom_range(0, 1) << 7) : 8'($urandom);
      if ($urandom_range(0, 19) == 0) begin clear = 1; step(1); clear = 0; end
      show(c, 1'($urandom_range(0, 1)), $urandom_range(1, 9));
    end
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
